// File: rtl/apb_gpio_periph_pkg.sv
// Shared definitions for the APB GPIO peripheral: register byte offsets and APB FSM states.
package gpio_pkg;

    localparam logic [4:0] GPIO_MODER   = 5'h00;
    localparam logic [4:0] GPIO_ODR     = 5'h04;
    localparam logic [4:0] GPIO_IDR     = 5'h08;
    localparam logic [4:0] GPIO_RISE_EN = 5'h0C;
    localparam logic [4:0] GPIO_FALL_EN = 5'h10;
    localparam logic [4:0] GPIO_ISR     = 5'h14;
    localparam logic [4:0] GPIO_IER     = 5'h18;

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS} apb_state_e;

endpackage

// File: rtl/apb_gpio_periph_if.sv
// APB slave-side bus bundle for the GPIO peripheral slot.
interface apb_gpio_periph_if;

    logic [31:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY
    );

endinterface

// File: rtl/apb_gpio_periph_edge_detect.sv
// Two-flop pad synchroniser plus previous-sample register; flags rising/falling edges per pin.
module gpio_edge_detect #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign sync = sync2;
    assign rise = sync2 & ~prev;
    assign fall = ~sync2 & prev;

endmodule

// File: rtl/apb_gpio_periph.sv
// APB GPIO peripheral: direction/output registers, synchronised inputs, and edge-triggered
// interrupt capture with write-1-to-clear status, behind an APB slave with optional wait states.
module apb_gpio_periph
    import gpio_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                PCLK,
    input  logic                PRESET,
    apb_gpio_periph_if.slave    apb,
    input  logic [WIDTH-1:0]    gpio_in,
    output logic [WIDTH-1:0]    gpio_out,
    output logic [WIDTH-1:0]    gpio_oe,
    output logic                irq
);

    localparam logic [2:0] WAIT_LAST = 3'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

    apb_state_e       state;
    apb_state_e       state_nxt;
    logic [2:0]       wait_cnt;
    logic             ready;
    logic             wr_en;
    logic             addr_hit;
    logic [4:0]       reg_sel;
    logic [WIDTH-1:0] wdata;
    logic [31:0]      rd_val;
    logic [31:0]      prdata_q;

    logic [WIDTH-1:0] moder;
    logic [WIDTH-1:0] odr;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] isr;
    logic [WIDTH-1:0] ier;
    logic [WIDTH-1:0] pin_sync;
    logic [WIDTH-1:0] pin_rise;
    logic [WIDTH-1:0] pin_fall;
    logic [WIDTH-1:0] isr_set;
    logic [WIDTH-1:0] isr_clr;
    logic             unused_bits;

    gpio_edge_detect #(.WIDTH(WIDTH)) u_edge (
        .clk   (PCLK),
        .rst_n (PRESET),
        .pin   (gpio_in),
        .sync  (pin_sync),
        .rise  (pin_rise),
        .fall  (pin_fall)
    );

    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (apb.PSEL && !apb.PENABLE) begin
                    state_nxt = (WAIT_STATES > 0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                if (!apb.PSEL) begin
                    state_nxt = IDLE;
                end else if (apb.PENABLE && wait_cnt == WAIT_LAST) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Only access-phase cycles (PENABLE high) count toward the wait budget.
    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            wait_cnt <= '0;
        end else if (state == WAIT && apb.PSEL && apb.PENABLE) begin
            wait_cnt <= wait_cnt + 3'd1;
        end else begin
            wait_cnt <= '0;
        end
    end

    assign ready       = (state == ACCESS);
    assign wr_en       = apb.PSEL & apb.PENABLE & apb.PWRITE & ready;
    assign addr_hit    = (apb.PADDR[31:5] == '0);
    assign reg_sel     = {apb.PADDR[4:2], 2'b00};
    assign wdata       = apb.PWDATA[WIDTH-1:0];
    assign unused_bits = ^{apb.PADDR[1:0], apb.PWDATA};

    always_comb begin
        rd_val = '0;
        if (addr_hit) begin
            case (reg_sel)
                GPIO_MODER:   rd_val[WIDTH-1:0] = moder;
                GPIO_ODR:     rd_val[WIDTH-1:0] = odr;
                GPIO_IDR:     rd_val[WIDTH-1:0] = pin_sync;
                GPIO_RISE_EN: rd_val[WIDTH-1:0] = rise_en;
                GPIO_FALL_EN: rd_val[WIDTH-1:0] = fall_en;
                GPIO_ISR:     rd_val[WIDTH-1:0] = isr;
                GPIO_IER:     rd_val[WIDTH-1:0] = ier;
                default:      rd_val = '0;
            endcase
        end
    end

    // Read data is captured on entry to ACCESS so it is stable for the whole PREADY cycle.
    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            prdata_q <= '0;
        end else begin
            prdata_q <= (state_nxt == ACCESS) ? rd_val : '0;
        end
    end

    assign isr_set = ((pin_rise & rise_en) | (pin_fall & fall_en)) & ~moder;
    assign isr_clr = (wr_en && addr_hit && reg_sel == GPIO_ISR) ? wdata : '0;

    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            moder   <= '0;
            odr     <= '0;
            rise_en <= '0;
            fall_en <= '0;
            isr     <= '0;
            ier     <= '0;
        end else begin
            // OR-ing the new events after the clear lets a same-cycle event win over W1C.
            isr <= (isr & ~isr_clr) | isr_set;
            if (wr_en && addr_hit) begin
                case (reg_sel)
                    GPIO_MODER:   moder   <= wdata;
                    GPIO_ODR:     odr     <= wdata;
                    GPIO_RISE_EN: rise_en <= wdata;
                    GPIO_FALL_EN: fall_en <= wdata;
                    GPIO_IER:     ier     <= wdata;
                    default:      ;
                endcase
            end
        end
    end

    assign apb.PREADY = ready;
    assign apb.PRDATA = prdata_q;
    assign gpio_oe    = moder;
    assign gpio_out   = odr & moder;
    assign irq        = |(isr & ier);

endmodule

// File: tb/tb_apb_gpio_periph.sv
// Scoreboard bench for apb_gpio_periph: random APB traffic and pad activity against a
// sample-history reference model of the register map and edge-capture rules.
module tb_apb_gpio_periph;

    localparam int W  = 8;
    localparam int WS = 3;

    logic         PCLK    = 1'b0;
    logic         PRESET  = 1'b0;
    logic [W-1:0] gpio_in = '0;
    logic [W-1:0] gpio_out;
    logic [W-1:0] gpio_oe;
    logic         irq;

    apb_gpio_periph_if bus();

    apb_gpio_periph #(.WIDTH(W), .WAIT_STATES(WS)) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .apb      (bus),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    always #5 PCLK = ~PCLK;

    int total = 0;
    int bad   = 0;

    logic [31:0] sb[$];

    // Reference model state
    logic [W-1:0] m_moder, m_odr, m_rise, m_fall, m_isr, m_ier;
    logic [W-1:0] smp[$];
    bit           m_valid = 1'b0;

    bit           cm_valid = 1'b0;
    logic [31:0]  cm_addr  = '0;
    logic [31:0]  cm_data  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge of the reference model. smp holds the pad value seen at each edge;
    // an edge at pad level is visible to capture two edges after it was sampled.
    task automatic model_step();
        logic [W-1:0] s_new, s_old, ev, clr;
        if (!PRESET) begin
            m_moder = '0; m_odr = '0; m_rise = '0; m_fall = '0; m_isr = '0; m_ier = '0;
            smp.delete();
            repeat (3) smp.push_back('0);
            m_valid = 1'b1;
        end else begin
            s_new = smp[smp.size()-2];
            s_old = smp[smp.size()-3];
            ev  = ((s_new & ~s_old & m_rise) | (~s_new & s_old & m_fall)) & ~m_moder;
            clr = '0;
            if (cm_valid && cm_addr[31:5] == 27'd0) begin
                case (cm_addr[4:2])
                    3'd0: m_moder = cm_data[W-1:0];
                    3'd1: m_odr   = cm_data[W-1:0];
                    3'd3: m_rise  = cm_data[W-1:0];
                    3'd4: m_fall  = cm_data[W-1:0];
                    3'd5: clr     = cm_data[W-1:0];
                    3'd6: m_ier   = cm_data[W-1:0];
                    default: ;
                endcase
            end
            m_isr = (m_isr & ~clr) | ev;
            smp.push_back(gpio_in);
            if (smp.size() > 8) void'(smp.pop_front());
        end
    endtask

    initial forever begin
        @(posedge PCLK);
        model_step();
    end

    // Expected read data, valid when pads have been quiet for several cycles.
    function automatic logic [31:0] exp_read(input logic [31:0] a);
        logic [31:0] r;
        r = '0;
        if (a[31:5] == 27'd0) begin
            case (a[4:2])
                3'd0: r[W-1:0] = m_moder;
                3'd1: r[W-1:0] = m_odr;
                3'd2: r[W-1:0] = smp[smp.size()-1];
                3'd3: r[W-1:0] = m_rise;
                3'd4: r[W-1:0] = m_fall;
                3'd5: r[W-1:0] = m_isr;
                3'd6: r[W-1:0] = m_ier;
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    // Monitor: pops read expectations on PREADY, checks pad-side outputs every cycle.
    always @(negedge PCLK) begin
        if (m_valid) begin
            check("gpio_oe", 32'(gpio_oe), 32'(m_moder));
            check("gpio_out", 32'(gpio_out), 32'(m_odr & m_moder));
            check("irq", 32'(irq), 32'(|(m_isr & m_ier)));
            if (!bus.PREADY) begin
                check("prdata_not_ready", bus.PRDATA, 32'h0);
            end else if (bus.PSEL && !bus.PWRITE) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_underflow: actual=unexpected_read required=none at %0t", $time);
                end else begin
                    check("prdata", bus.PRDATA, sb.pop_front());
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic apb_xfer(input bit wr, input logic [31:0] a, input logic [31:0] d);
        int waits;
        waits = 0;
        if (!wr) sb.push_back(exp_read(a));
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr; bus.PADDR = a; bus.PWDATA = d;
        @(negedge PCLK);
        bus.PENABLE = 1'b1;
        while (!bus.PREADY && waits < 40) begin
            @(negedge PCLK);
            waits++;
        end
        check("wait_cycles", 32'(waits), 32'(WS));
        if (bus.PREADY && wr) begin
            cm_valid = 1'b1; cm_addr = a; cm_data = d;
        end
        @(negedge PCLK);
        cm_valid = 1'b0;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    endtask

    task automatic wiggle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge PCLK);
            gpio_in = W'($urandom);
        end
        idle(4);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int op;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = '0; bus.PWDATA = '0;

        PRESET = 1'b0;
        idle(2);
        PRESET = 1'b1;
        for (int i = 0; i < 8; i++) apb_xfer(1'b0, 32'(i * 4), '0);

        // Output path
        apb_xfer(1'b1, 32'h00, 32'h0000_000F);
        apb_xfer(1'b1, 32'h04, 32'h0000_00FF);
        check("oe_0f", 32'(gpio_oe), 32'h0F);
        check("out_0f", 32'(gpio_out), 32'h0F);
        apb_xfer(1'b0, 32'h04, '0);

        // Rising edge on pin 0 raises irq two edges later; W1C drops it.
        apb_xfer(1'b1, 32'h00, 32'h0);
        apb_xfer(1'b1, 32'h0C, 32'h1);
        apb_xfer(1'b1, 32'h18, 32'h1);
        gpio_in[0] = 1'b1;
        idle(2);
        check("irq_early", 32'(irq), 32'h0);
        idle(1);
        check("irq_rise", 32'(irq), 32'h1);
        idle(2);
        apb_xfer(1'b0, 32'h14, '0);
        apb_xfer(1'b1, 32'h14, 32'h1);
        check("irq_clear", 32'(irq), 32'h0);

        // Falling edge on pin 3 lands on the same edge as its W1C commit.
        apb_xfer(1'b1, 32'h0C, 32'h08);
        apb_xfer(1'b1, 32'h10, 32'h08);
        apb_xfer(1'b1, 32'h18, 32'h08);
        gpio_in[3] = 1'b1;
        idle(4);
        check("irq_pin3", 32'(irq), 32'h1);
        fork
            apb_xfer(1'b1, 32'h14, 32'h08);
            begin
                repeat (WS - 1) @(negedge PCLK);
                gpio_in[3] = 1'b0;
            end
        join
        check("set_wins", 32'(irq), 32'h1);
        idle(3);
        apb_xfer(1'b0, 32'h14, '0);
        apb_xfer(1'b1, 32'h14, 32'h08);
        check("irq_pin3_clear", 32'(irq), 32'h0);

        // Unmapped offset
        apb_xfer(1'b1, 32'h1C, 32'hDEAD_BEEF);
        for (int i = 0; i < 8; i++) apb_xfer(1'b0, 32'(i * 4), '0);

        // PSEL dropped mid-wait: no write
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = 32'h00; bus.PWDATA = 32'hAA;
        idle(1);
        bus.PENABLE = 1'b1;
        idle(1);
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        idle(3);
        apb_xfer(1'b0, 32'h00, '0);

        // Reset in the middle of a write
        apb_xfer(1'b1, 32'h04, 32'h55);
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = 32'h00; bus.PWDATA = 32'hFF;
        idle(1);
        bus.PENABLE = 1'b1;
        PRESET = 1'b0;
        idle(2);
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        PRESET = 1'b1;
        idle(3);
        for (int i = 0; i < 7; i++) apb_xfer(1'b0, 32'(i * 4), '0);

        // Random traffic
        for (int i = 0; i < 80; i++) begin
            op = int'($urandom_range(0, 4));
            a  = 32'(4 * $urandom_range(0, 9));
            case (op)
                0, 1: apb_xfer(1'b1, a, $urandom);
                2:    apb_xfer(1'b0, a, '0);
                3:    wiggle(int'($urandom_range(2, 8)));
                default: apb_xfer(1'b1, 32'h14, $urandom);
            endcase
        end
        for (int i = 0; i < 7; i++) apb_xfer(1'b0, 32'(i * 4), '0);

        idle(3);
        check("scoreboard_drain", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
